udp_sweep_ctrl: RTL

//  Exhaustive truth-table sweep controller for a combinational N-input UDP

---
 rtl/udp_sweep_pkg.sv | 17 +
 rtl/udp_sweep_cnt.sv | 29 ++
 rtl/udp_sweep_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/udp_sweep_pkg.sv
// Shared types and helpers for the UDP truth-table sweep controller.
package udp_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } sweep_state_t;

  localparam int unsigned SETTLE_W = 4;

  function automatic int unsigned TABLE_SZ(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/udp_sweep_cnt.sv
// Vector index counter for the sweep: synchronous clear, saturating increment.
module udp_sweep_cnt
  import udp_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [N_IN:0] idx,
  output logic          last
);

  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TABLE_SZ(N_IN) - 1);

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc && !last) begin
      idx <= idx + (N_IN+1)'(1);
    end
  end

endmodule

// File: rtl/udp_sweep_ctrl.sv
// Exhaustive truth-table sweep controller for an N_IN-input combinational target.
// Optional first-mismatch reporting ports: define UDP_SWEEP_FAIL_IDX_EN.
module udp_sweep_ctrl
  import udp_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [TABLE_SZ(N_IN)-1:0]   expected,
  output logic [N_IN-1:0]             stim,
  input  logic                        dut_out,
  output logic                        busy,
  output logic                        done,
  output logic [TABLE_SZ(N_IN)-1:0]   result,
  output logic                        pass
`ifdef UDP_SWEEP_FAIL_IDX_EN
  ,
  output logic                        fail_valid,
  output logic [N_IN-1:0]             fail_idx
`endif
);

  sweep_state_t        state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q;
  logic [N_IN:0]       idx;
  logic [N_IN-1:0]     idx_lo;
  logic                last;
  logic                pass_q;
  logic                sweep_start, capture, idx_inc, finish, abort_go;

  assign idx_lo = idx[N_IN-1:0];

  udp_sweep_cnt #(.N_IN(N_IN)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sweep_start),
    .inc   (idx_inc),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sweep_start = 1'b0;
    capture     = 1'b0;
    idx_inc     = 1'b0;
    finish      = 1'b0;
    abort_go    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          sweep_start = 1'b1;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          abort_go = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == SETTLE_W'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          abort_go = 1'b1;
          state_d  = S_IDLE;
        end else begin
          capture = 1'b1;
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_inc = 1'b1;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Settle counter restarts whenever SETTLE is (re)entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_SETTLE && state_d == S_SETTLE) begin
      cnt_q <= cnt_q + SETTLE_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim   <= '0;
      result <= '0;
      pass_q <= 1'b0;
    end else begin
      if (sweep_start) begin
        stim   <= '0;
        result <= '0;
        pass_q <= 1'b0;
      end
      if (capture) begin
        result[idx_lo] <= dut_out;
        if (!last) stim <= N_IN'(idx + (N_IN+1)'(1));
      end
      if (abort_go) begin
        stim   <= '0;
        pass_q <= 1'b0;
      end
      if (finish) pass_q <= (result == expected);
    end
  end

  // pass is compared live during DONE so it is valid alongside the done pulse,
  // then held from the register until the next start.
  assign done = (state_q == S_DONE);
  assign busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign pass = (state_q == S_DONE) ? (result == expected) : pass_q;

`ifdef UDP_SWEEP_FAIL_IDX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else if (sweep_start) begin
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else if (capture && !fail_valid && (dut_out != expected[idx_lo])) begin
      fail_valid <= 1'b1;
      fail_idx   <= idx_lo;
    end
  end
`endif

endmodule
